maze_bfs_solver: RTL and testbench

Parametrised N×N maze solver for the maze-search datapath. Loads a serial bitmap of an N×N maze, runs a breadth-first search from start cell (1,1) to goal cell (N-2,N-2), and streams the shortest path, goal first, one coordinate per cycle. Mazes with no path, a blocked start or goal, or a queue overflow are reported with a single-cycle `maze_not_valid` pulse.

---
 rtl/maze_bfs_solver.sv | 228 ++++++++++++++++++++++
 tb/tb_maze_bfs_solver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_bfs_solver.sv
// maze_bfs_solver: loads an N x N wall bitmap serially, runs a breadth-first search from
// (1,1) to (N-2,N-2) and streams the shortest path goal-first, one cell per cycle.
// Unreachable goal, walled start/goal or frontier overflow yield a one-cycle failure report.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       maze carries a bit this cycle (only honoured while idle in LOAD)
//   maze           cell bit, 1 = wall, row-major from (0,0)
//   busy           solver occupied; input bits are dropped while high
//   out_valid      out_x/out_y valid, or failure report when maze_not_valid is high
//   maze_not_valid failure flag, only together with out_valid
//   out_x, out_y   path column / row
module maze_bfs_solver #(
    parameter int unsigned N      = 15,
    parameter int unsigned QDEPTH = 64,
    localparam int unsigned W     = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         maze,
    output logic         busy,
    output logic         out_valid,
    output logic         maze_not_valid,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned PW = $clog2(QDEPTH);

    localparam logic [IW-1:0] StartIdx = IW'(N + 1);
    localparam logic [IW-1:0] GoalIdx  = IW'((N - 2) * N + (N - 2));
    localparam logic [W-1:0]  GoalRc   = W'(N - 2);
    localparam logic [W-1:0]  StartRc  = W'(1);

    typedef enum logic [2:0] {StLoad, StCheck, StSearch, StTrace, StFail} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [NN-1:0]     wall_q, visited_q;
    logic [1:0]        parent_q [NN];
    logic [2*W-1:0]    fifo_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       occ_q, occ_d;
    logic [W-1:0]      cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [2:0]        step_q, step_d;     // 0..3 probe right/up/left/down, 4 = pop
    logic              out_valid_q, out_valid_d, not_valid_q, not_valid_d;
    logic [W-1:0]      out_x_q, out_x_d, out_y_q, out_y_d;

    logic [W:0]        nb_row, nb_col;
    logic              nb_open;
    logic [IW-1:0]     nb_idx, cur_idx, mark_idx;
    logic              load_en, clear_en, mark_en, push_en;

    function automatic logic [IW-1:0] cell_idx(input logic [W-1:0] r, input logic [W-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    assign cur_idx = cell_idx(cur_row_q, cur_col_q);

    // Neighbour at W+1 bits: stepping below 0 wraps to a value >= N, so one range test covers both edges.
    always_comb begin
        nb_row = {1'b0, cur_row_q};
        nb_col = {1'b0, cur_col_q};
        unique case (step_q[1:0])
            2'd0: nb_col = {1'b0, cur_col_q} + (W+1)'(1);
            2'd1: nb_row = {1'b0, cur_row_q} - (W+1)'(1);
            2'd2: nb_col = {1'b0, cur_col_q} - (W+1)'(1);
            2'd3: nb_row = {1'b0, cur_row_q} + (W+1)'(1);
        endcase
        nb_idx  = cell_idx(nb_row[W-1:0], nb_col[W-1:0]);
        nb_open = (nb_row < (W+1)'(N)) && (nb_col < (W+1)'(N)) &&
                  !wall_q[nb_idx] && !visited_q[nb_idx];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        out_valid_d = 1'b0;
        not_valid_d = 1'b0;
        out_x_d     = '0;
        out_y_d     = '0;
        load_en     = 1'b0;
        clear_en    = 1'b0;
        mark_en     = 1'b0;
        mark_idx    = nb_idx;
        push_en     = 1'b0;
        unique case (state_q)
            StLoad: begin
                // The final output beat still counts as busy, so its bit is dropped.
                if (in_valid && !out_valid_q) begin
                    load_en = 1'b1;
                    if (cnt_q == IW'(NN - 1)) begin
                        cnt_d    = '0;
                        clear_en = 1'b1;
                        state_d  = StCheck;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            StCheck: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                occ_d    = '0;
                step_d   = '0;
                if (wall_q[StartIdx] || wall_q[GoalIdx]) begin
                    state_d = StFail;
                end else begin
                    mark_en   = 1'b1;
                    mark_idx  = StartIdx;
                    cur_row_d = StartRc;
                    cur_col_d = StartRc;
                    state_d   = StSearch;
                end
            end
            StSearch: begin
                if (step_q == 3'd4) begin
                    step_d = '0;
                    if (occ_q == '0) begin
                        state_d = StFail;
                    end else begin
                        {cur_row_d, cur_col_d} = fifo_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        occ_d    = occ_q - (PW+1)'(1);
                    end
                end else begin
                    step_d = step_q + 3'd1;
                    if (nb_open) begin
                        if (occ_q == (PW+1)'(QDEPTH)) begin
                            state_d = StFail;
                        end else begin
                            mark_en  = 1'b1;
                            push_en  = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            occ_d    = occ_q + (PW+1)'(1);
                            if (nb_row == {1'b0, GoalRc} && nb_col == {1'b0, GoalRc}) begin
                                cur_row_d = GoalRc;
                                cur_col_d = GoalRc;
                                state_d   = StTrace;
                            end
                        end
                    end
                end
            end
            StTrace: begin
                out_valid_d = 1'b1;
                out_x_d     = cur_col_q;
                out_y_d     = cur_row_q;
                if (cur_row_q == StartRc && cur_col_q == StartRc) begin
                    state_d = StLoad;
                end else begin
                    unique case (parent_q[cur_idx])
                        2'd0: cur_col_d = cur_col_q + W'(1);
                        2'd1: cur_row_d = cur_row_q - W'(1);
                        2'd2: cur_col_d = cur_col_q - W'(1);
                        2'd3: cur_row_d = cur_row_q + W'(1);
                    endcase
                end
            end
            StFail: begin
                out_valid_d = 1'b1;
                not_valid_d = 1'b1;
                state_d     = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            wall_q      <= '0;
            visited_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            not_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            for (int i = 0; i < NN; i++) parent_q[i] <= 2'd0;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
            not_valid_q <= not_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            if (load_en) wall_q[cnt_q] <= maze;
            if (clear_en) begin
                visited_q <= '0;
            end else if (mark_en) begin
                visited_q[mark_idx] <= 1'b1;
                // Direction from the new cell back to the one that discovered it.
                parent_q[mark_idx]  <= step_q[1:0] ^ 2'd2;
            end
            if (push_en) fifo_q[wr_ptr_q] <= {nb_row[W-1:0], nb_col[W-1:0]};
        end
    end

    assign busy           = (state_q != StLoad) || out_valid_q;
    assign out_valid      = out_valid_q;
    assign maze_not_valid = not_valid_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;

endmodule

// File: tb/tb_maze_bfs_solver.sv
// Directed bench for maze_bfs_solver: three instances (N=5/Q64, N=15/Q64, N=15/Q4) driven from
// a scenario table, with a software BFS reference for path contents and hand-written sequences
// for reset during trace and gapped loading.
module tb_maze_bfs_solver;

    typedef struct {
        int dut;        // 0: N=5 Q=64, 1: N=15 Q=64, 2: N=15 Q=4
        int pattern;    // 0 corridor, 1 corridor with goal walled, 2 open interior, 3 row 7 walled
        bit gaps;
        bit exp_fail;
        int exp_len;
        int exp_x0;
        int exp_y0;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, iv, maze_bit;
    int         sel;
    logic       iv5, iv15, iv15q;
    logic       b5, ov5, nv5, b15, ov15, nv15, bq, ovq, nvq;
    logic [2:0] x5, y5;
    logic [3:0] x15, y15, xq, yq;
    logic       o_busy, o_ov, o_nv;
    logic [3:0] o_x, o_y;

    assign iv5   = iv && (sel == 0);
    assign iv15  = iv && (sel == 1);
    assign iv15q = iv && (sel == 2);

    maze_bfs_solver #(.N(5), .QDEPTH(64)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .maze(maze_bit), .busy(b5),
        .out_valid(ov5), .maze_not_valid(nv5), .out_x(x5), .out_y(y5));
    maze_bfs_solver #(.N(15), .QDEPTH(64)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv15), .maze(maze_bit), .busy(b15),
        .out_valid(ov15), .maze_not_valid(nv15), .out_x(x15), .out_y(y15));
    maze_bfs_solver #(.N(15), .QDEPTH(4)) u_dut15q (
        .clk(clk), .rst_n(rst_n), .in_valid(iv15q), .maze(maze_bit), .busy(bq),
        .out_valid(ovq), .maze_not_valid(nvq), .out_x(xq), .out_y(yq));

    always_comb begin
        o_busy = b5;
        o_ov   = ov5;
        o_nv   = nv5;
        o_x    = {1'b0, x5};
        o_y    = {1'b0, y5};
        if (sel == 1) begin
            o_busy = b15; o_ov = ov15; o_nv = nv15; o_x = x15; o_y = y15;
        end else if (sel == 2) begin
            o_busy = bq; o_ov = ovq; o_nv = nvq; o_x = xq; o_y = yq;
        end
    end

    int   checks = 0;
    int   errors = 0;
    bit   mz [225];
    int   mx [64], my [64], mlen;
    int   gx [64], gy [64], g_len, g_fail_cyc, g_fail_xy;
    bit   g_busy_last, g_busy_after, g_timeout;
    vec_t vecs [6];
    int   cyc, mism, adj_bad, dxy;
    int   cx [5], cy [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic build(input int pattern, input int n);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                bit open;
                if (pattern <= 1)
                    open = (r == 1 && c >= 1 && c <= 3) || (c == 3 && r >= 2 && r <= 3);
                else
                    open = (r >= 1 && r <= n - 2 && c >= 1 && c <= n - 2);
                if (pattern == 1 && r == 3 && c == 3) open = 1'b0;
                if (pattern == 3 && r == 7) open = 1'b0;
                mz[r * n + c] = !open;
            end
        end
    endtask

    // Reference BFS, probe order right/up/left/down, unbounded queue; path goal-first.
    task automatic sw_bfs(input int n);
        int q [$];
        int par [225];
        bit vis [225];
        int dr [4];
        int dc [4];
        int cur, nb, nr, nc, start, goal;
        bit found;
        dr = '{0, -1, 0, 1};
        dc = '{1, 0, -1, 0};
        mlen = 0;
        found = 1'b0;
        start = n + 1;
        goal = (n - 2) * n + (n - 2);
        for (int i = 0; i < 225; i++) begin vis[i] = 1'b0; par[i] = 0; end
        if (!mz[start] && !mz[goal]) begin
            vis[start] = 1'b1;
            q.push_back(start);
            while (q.size() > 0 && !found) begin
                cur = q.pop_front();
                for (int d = 0; d < 4 && !found; d++) begin
                    nr = cur / n + dr[d];
                    nc = cur % n + dc[d];
                    if (nr >= 0 && nr < n && nc >= 0 && nc < n) begin
                        nb = nr * n + nc;
                        if (!mz[nb] && !vis[nb]) begin
                            vis[nb] = 1'b1;
                            par[nb] = cur;
                            q.push_back(nb);
                            if (nb == goal) found = 1'b1;
                        end
                    end
                end
            end
            if (found) begin
                cur = goal;
                while (mlen < 64) begin
                    mx[mlen] = cur % n;
                    my[mlen] = cur / n;
                    mlen++;
                    if (cur == start) break;
                    cur = par[cur];
                end
            end
        end
    endtask

    task automatic load_maze(input int n, input bit gaps);
        int g;
        for (int i = 0; i < n * n; i++) begin
            if (gaps) begin
                g = $urandom_range(1, 3);
                repeat (g) begin
                    @(negedge clk);
                    iv = 1'b0;
                    maze_bit = ~mz[i];
                end
            end
            @(negedge clk);
            iv = 1'b1;
            maze_bit = mz[i];
        end
        @(negedge clk);
        iv = 1'b0;
    endtask

    // Records one result burst; drives junk bits whenever busy is seen high.
    task automatic collect(input int budget);
        bit seen, done;
        int n_cyc;
        seen = 1'b0; done = 1'b0; n_cyc = 0;
        g_len = 0; g_fail_cyc = 0; g_fail_xy = 0; g_busy_last = 1'b0; g_busy_after = 1'b1;
        while (!done && n_cyc < budget) begin
            @(negedge clk);
            n_cyc++;
            if (o_ov) begin
                seen = 1'b1;
                g_busy_last = o_busy;
                if (o_nv) begin
                    g_fail_cyc++;
                    g_fail_xy = g_fail_xy + int'(o_x) + int'(o_y);
                end else begin
                    if (g_len < 64) begin gx[g_len] = int'(o_x); gy[g_len] = int'(o_y); end
                    g_len++;
                end
            end else if (seen) begin
                g_busy_after = o_busy;
                done = 1'b1;
            end
            iv = o_busy && !done;
            maze_bit = 1'b1;
        end
        iv = 1'b0;
        g_timeout = !done;
    endtask

    initial begin
        vecs[0] = '{0, 0, 1'b0, 1'b0, 5, 3, 3};
        vecs[1] = '{0, 1, 1'b0, 1'b1, 0, 0, 0};
        vecs[2] = '{0, 0, 1'b1, 1'b0, 5, 3, 3};
        vecs[3] = '{1, 2, 1'b0, 1'b0, 25, 13, 13};
        vecs[4] = '{1, 3, 1'b0, 1'b1, 0, 0, 0};
        vecs[5] = '{2, 2, 1'b0, 1'b1, 0, 0, 0};
        cx = '{3, 3, 3, 2, 1};
        cy = '{3, 2, 1, 1, 1};

        rst_n = 1'b0; iv = 1'b0; maze_bit = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("reset_d%0d_out_valid", s), o_ov, 0);
            check($sformatf("reset_d%0d_not_valid", s), o_nv, 0);
            check($sformatf("reset_d%0d_busy", s), o_busy, 0);
            check($sformatf("reset_d%0d_xy", s), {o_x, o_y}, 0);
        end

        for (int i = 0; i < 6; i++) begin
            int n;
            sel = vecs[i].dut;
            n = (vecs[i].dut == 0) ? 5 : 15;
            build(vecs[i].pattern, n);
            sw_bfs(n);
            load_maze(n, vecs[i].gaps);
            collect(3000);
            check($sformatf("v%0d_timeout", i), g_timeout, 0);
            check($sformatf("v%0d_fail_pulses", i), g_fail_cyc, vecs[i].exp_fail ? 1 : 0);
            check($sformatf("v%0d_len", i), g_len, vecs[i].exp_len);
            check($sformatf("v%0d_busy_last", i), g_busy_last, 1);
            check($sformatf("v%0d_busy_after", i), g_busy_after, 0);
            if (vecs[i].exp_fail) begin
                check($sformatf("v%0d_fail_xy", i), g_fail_xy, 0);
            end else begin
                check($sformatf("v%0d_first_x", i), gx[0], vecs[i].exp_x0);
                check($sformatf("v%0d_first_y", i), gy[0], vecs[i].exp_y0);
                check($sformatf("v%0d_last_xy", i), {gx[g_len-1][3:0], gy[g_len-1][3:0]}, 8'h11);
                check($sformatf("v%0d_model_len", i), g_len, mlen);
                mism = 0;
                adj_bad = 0;
                for (int k = 0; k < g_len && k < mlen && k < 64; k++)
                    if (gx[k] != mx[k] || gy[k] != my[k]) mism++;
                for (int k = 1; k < g_len && k < 64; k++) begin
                    dxy = (gx[k] > gx[k-1] ? gx[k] - gx[k-1] : gx[k-1] - gx[k]) +
                          (gy[k] > gy[k-1] ? gy[k] - gy[k-1] : gy[k-1] - gy[k]);
                    if (dxy != 1) adj_bad++;
                end
                check($sformatf("v%0d_model_path", i), mism, 0);
                check($sformatf("v%0d_adjacent", i), adj_bad, 0);
            end
        end

        // Reset while the corridor path is being traced.
        sel = 0;
        build(0, 5);
        load_maze(5, 1'b0);
        cyc = 0;
        while (!o_ov && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_trace", o_ov, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", o_ov, 0);
        check("rst_not_valid", o_nv, 0);
        check("rst_busy", o_busy, 0);
        check("rst_xy", {o_x, o_y}, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_out_valid", o_ov, 0);
        check("rst_hold_busy", o_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_busy", o_busy, 0);

        // Reload with random gaps; the same explicit corridor path is required.
        load_maze(5, 1'b1);
        collect(500);
        check("gap_timeout", g_timeout, 0);
        check("gap_len", g_len, 5);
        check("gap_fail_pulses", g_fail_cyc, 0);
        check("gap_busy_after", g_busy_after, 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("gap_x%0d", k), gx[k], cx[k]);
            check($sformatf("gap_y%0d", k), gy[k], cy[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
